// File: rtl/usb_stat_cnt_ctrl_if.sv
// ============================================================================
// Module  : usb_stat_cnt_ctrl_if
// Brief   : Host readout bus for the statistics counter bank.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface usb_stat_cnt_ctrl_if #(
    parameter int W  = 16,
    parameter int AW = 2
);
    logic          rd_req_i;
    logic [AW-1:0] rd_addr_i;
    logic          rd_ack_o;
    logic [W-1:0]  rd_data_o;

    modport master (
        output rd_req_i,
        output rd_addr_i,
        input  rd_ack_o,
        input  rd_data_o
    );

    modport slave (
        input  rd_req_i,
        input  rd_addr_i,
        output rd_ack_o,
        output rd_data_o
    );
endinterface

`default_nettype wire

// File: rtl/usb_stat_cnt_ctrl.sv
// ============================================================================
// Module  : usb_stat_cnt_ctrl
// Brief   : Round-robin shared incrementer for NCNT statistics counters with
//           readout and clear sweep. Define STAT_CNT_SAT_EN for saturating counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module usb_stat_cnt_ctrl #(
    parameter int NCNT = 4,
    parameter int W    = 16,
    parameter int PW   = 2,
    parameter int AW   = 2
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    input  wire logic [NCNT-1:0]  evt_i,
    input  wire logic             clr_i,
    output logic                  busy_o,
    output logic [NCNT-1:0]       lost_o,
    output logic [NCNT-1:0]       grant_o,
    usb_stat_cnt_ctrl_if.slave    rd_if
);

    localparam int IW = (NCNT > 1) ? $clog2(NCNT) : 1;
    localparam logic [PW-1:0] PEND_MAX = '1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [W-1:0]    cnt_q  [NCNT];
    logic [W-1:0]    cnt_d  [NCNT];
    logic [PW-1:0]   pend_q [NCNT];
    logic [PW-1:0]   pend_d [NCNT];
    logic [NCNT-1:0] lost_q, lost_d;
    logic            rd_ack_q, rd_ack_d;
    logic [W-1:0]    rd_data_q, rd_data_d;

    logic [NCNT-1:0] gnt;
    logic            gnt_vld;
    logic [IW-1:0]   gnt_idx;

    // Two-pass search: first at/above the pointer, then wrap to the bottom.
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        if (state_q == ST_IDLE) begin
            for (int i = 0; i < NCNT; i++) begin
                if (!gnt_vld && (pend_q[i] != '0) && (IW'(i) >= ptr_q)) begin
                    gnt_vld = 1'b1;
                    gnt_idx = IW'(i);
                end
            end
            for (int i = 0; i < NCNT; i++) begin
                if (!gnt_vld && (pend_q[i] != '0)) begin
                    gnt_vld = 1'b1;
                    gnt_idx = IW'(i);
                end
            end
            for (int i = 0; i < NCNT; i++) begin
                gnt[i] = gnt_vld && (gnt_idx == IW'(i));
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        lost_d    = lost_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        rd_ack_d  = rd_if.rd_req_i;
        rd_data_d = rd_data_q;

        if (rd_if.rd_req_i) begin
            rd_data_d = '0;
            for (int i = 0; i < NCNT; i++) begin
                if (rd_if.rd_addr_i == AW'(i)) begin
                    rd_data_d = cnt_q[i];
                end
            end
        end

        for (int i = 0; i < NCNT; i++) begin
            if (evt_i[i] && !gnt[i]) begin
                if (pend_q[i] == PEND_MAX) begin
                    lost_d[i] = 1'b1;
                end else begin
                    pend_d[i] = pend_q[i] + 1'b1;
                end
            end else if (!evt_i[i] && gnt[i]) begin
                pend_d[i] = pend_q[i] - 1'b1;
            end
        end

        if (gnt_vld) begin
            ptr_d = (gnt_idx == IW'(NCNT - 1)) ? '0 : gnt_idx + 1'b1;
            for (int i = 0; i < NCNT; i++) begin
                if (gnt[i]) begin
`ifdef STAT_CNT_SAT_EN
                    if (cnt_q[i] != '1) begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
`else
                    cnt_d[i] = cnt_q[i] + 1'b1;
`endif
                end
            end
        end

        // Sweep end clears lost flags last so it wins over a same-cycle drop.
        case (state_q)
            ST_IDLE: begin
                if (clr_i) begin
                    state_d = ST_CLEAR;
                    idx_d   = '0;
                end
            end
            ST_CLEAR: begin
                for (int i = 0; i < NCNT; i++) begin
                    if (idx_q == IW'(i)) begin
                        cnt_d[i] = '0;
                    end
                end
                if (idx_q == IW'(NCNT - 1)) begin
                    state_d = ST_IDLE;
                    lost_d  = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            ptr_q     <= '0;
            lost_q    <= '0;
            rd_ack_q  <= 1'b0;
            rd_data_q <= '0;
            for (int i = 0; i < NCNT; i++) begin
                cnt_q[i]  <= '0;
                pend_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            lost_q    <= lost_d;
            rd_ack_q  <= rd_ack_d;
            rd_data_q <= rd_data_d;
            for (int i = 0; i < NCNT; i++) begin
                cnt_q[i]  <= cnt_d[i];
                pend_q[i] <= pend_d[i];
            end
        end
    end

    assign busy_o          = (state_q == ST_CLEAR);
    assign lost_o          = lost_q;
    assign grant_o         = gnt;
    assign rd_if.rd_ack_o  = rd_ack_q;
    assign rd_if.rd_data_o = rd_data_q;

endmodule

`default_nettype wire
